// File: rtl/exmem_arbiter.sv
// Two-requester arbiter sharing the single-port exmem RAM between the CPU and the audio engine.
// Optional macro STARVE_GUARD_EN bounds how long audio traffic can lock out the CPU.
module exmem_arbiter #(
    parameter int WIDTH         = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [WIDTH-1:0]         cpu_rdata,

    input  logic                     aud_req,
    input  logic                     aud_we,
    input  logic [RAM_ADDR_BITS-1:0] aud_adr,
    input  logic [WIDTH-1:0]         aud_wdata,
    output logic                     aud_gnt,
    output logic                     aud_rvalid,
    output logic [WIDTH-1:0]         aud_rdata,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    logic starve;
    logic rd_pend;
    logic rd_own;
    logic rd_grant;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(MAX_WAIT);

    logic [WAIT_BITS-1:0] wait_cnt;

    assign starve = cpu_req && (wait_cnt == WAIT_LIMIT);

    // Counts consecutive denied CPU cycles; saturates so the override persists until the CPU is served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // Never true for a legal MAX_WAIT; without the guard audio priority is absolute.
    assign starve = (MAX_WAIT < 0);
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        aud_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (starve || !aud_req)) begin
                cpu_gnt = 1'b1;
            end else if (aud_req) begin
                aud_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (aud_gnt) begin
            mem_we    = aud_we;
            mem_adr   = aud_adr;
            mem_wdata = aud_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
        end
    end

    assign mem_en   = cpu_gnt | aud_gnt;
    assign rd_grant = mem_en & ~mem_we;

    // Remembers who issued the read so the returning word reaches only that requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_own  <= 1'b0;
        end else begin
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_own <= aud_gnt;
            end
        end
    end

    assign cpu_rvalid = ~reset & rd_pend & ~rd_own;
    assign aud_rvalid = ~reset & rd_pend & rd_own;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign aud_rdata  = aud_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_exmem_arbiter.sv
// Self-checking bench for exmem_arbiter: vector table plus starvation and mid-read reset sequences.
// A behavioural single-port RAM with one-cycle read latency stands in for exmem.
module tb_exmem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [9:0]  cpu_adr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        aud_req, aud_we, aud_gnt, aud_rvalid;
    logic [9:0]  aud_adr;
    logic [31:0] aud_wdata, aud_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_adr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        cr, cw;
        logic [9:0]  ca;
        logic [31:0] cd;
        logic        ar, aw;
        logic [9:0]  aa;
        logic [31:0] ad;
        logic        ecg, eag, ecv;
        logic [31:0] ecd;
        logic        eav;
        logic [31:0] ead;
        logic        een, ewe;
        logic [9:0]  eadr;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs[$];

    exmem_arbiter #(.WIDTH(32), .RAM_ADDR_BITS(10), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aud_req(aud_req), .aud_we(aud_we), .aud_adr(aud_adr), .aud_wdata(aud_wdata),
        .aud_gnt(aud_gnt), .aud_rvalid(aud_rvalid), .aud_rdata(aud_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= 32'(i);
        mem_rdata <= '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_adr] <= mem_wdata;
            else        mem_rdata    <= ram[mem_adr];
        end
    end

    function automatic vec_t mkv(
        input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
        input logic ar, input logic aw, input logic [9:0] aa, input logic [31:0] ad,
        input logic ecg, input logic eag, input logic ecv, input logic [31:0] ecd,
        input logic eav, input logic [31:0] ead,
        input logic een, input logic ewe, input logic [9:0] eadr, input logic [31:0] ewd);
        vec_t v;
        v.cr = cr;   v.cw = cw;   v.ca = ca;   v.cd = cd;
        v.ar = ar;   v.aw = aw;   v.aa = aa;   v.ad = ad;
        v.ecg = ecg; v.eag = eag; v.ecv = ecv; v.ecd = ecd;
        v.eav = eav; v.ead = ead;
        v.een = een; v.ewe = ewe; v.eadr = eadr; v.ewd = ewd;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic applyStimulus(input vec_t v);
        cpu_req = v.cr; cpu_we = v.cw; cpu_adr = v.ca; cpu_wdata = v.cd;
        aud_req = v.ar; aud_we = v.aw; aud_adr = v.aa; aud_wdata = v.ad;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("v%0d cpu_gnt", idx),    32'(cpu_gnt),    32'(v.ecg));
        checkVal($sformatf("v%0d aud_gnt", idx),    32'(aud_gnt),    32'(v.eag));
        checkVal($sformatf("v%0d cpu_rvalid", idx), 32'(cpu_rvalid), 32'(v.ecv));
        checkVal($sformatf("v%0d cpu_rdata", idx),  cpu_rdata,       v.ecd);
        checkVal($sformatf("v%0d aud_rvalid", idx), 32'(aud_rvalid), 32'(v.eav));
        checkVal($sformatf("v%0d aud_rdata", idx),  aud_rdata,       v.ead);
        checkVal($sformatf("v%0d mem_en", idx),     32'(mem_en),     32'(v.een));
        checkVal($sformatf("v%0d mem_we", idx),     32'(mem_we),     32'(v.ewe));
        checkVal($sformatf("v%0d mem_adr", idx),    32'(mem_adr),    32'(v.eadr));
        checkVal($sformatf("v%0d mem_wdata", idx),  mem_wdata,       v.ewd);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        logic exp_cpu;

        idle = mkv(L, L, '0, '0, L, L, '0, '0, L, L, L, '0, L, '0, L, L, '0, '0);

        // Reset state: requests present but nothing may be granted while reset is high.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 10'd3; cpu_wdata = '0;
        aud_req = 1'b1; aud_we = 1'b0; aud_adr = 10'd4; aud_wdata = '0;
        #2;
        checkVal("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkVal("rst aud_gnt", 32'(aud_gnt), 32'd0);
        checkVal("rst mem_en",  32'(mem_en),  32'd0);
        checkVal("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkVal("rst aud_rvalid", 32'(aud_rvalid), 32'd0);
        applyStimulus(idle);
        stepCycle();
        stepCycle();
        reset = 1'b0;

        // CPU write then read-back at the top address
        vecs.push_back(mkv(H, H, 10'h3FF, 32'hDEADBEEF, L, L, '0, '0, H, L, L, '0, L, '0, H, H, 10'h3FF, 32'hDEADBEEF));
        vecs.push_back(mkv(H, L, 10'h3FF, '0, L, L, '0, '0, H, L, L, '0, L, '0, H, L, 10'h3FF, '0));
        vecs.push_back(mkv(L, L, '0, '0, L, L, '0, '0, L, L, H, 32'hDEADBEEF, L, '0, L, L, '0, '0));
        // Contention: audio first, CPU the cycle after
        vecs.push_back(mkv(H, L, 10'd5, '0, H, L, 10'd6, '0, L, H, L, '0, L, '0, H, L, 10'd6, '0));
        vecs.push_back(mkv(H, L, 10'd5, '0, L, L, '0, '0, H, L, L, '0, H, 32'h6, H, L, 10'd5, '0));
        vecs.push_back(mkv(L, L, '0, '0, L, L, '0, '0, L, L, H, 32'h5, L, '0, L, L, '0, '0));
        // Audio streaming reads of 0..7
        for (int k = 0; k < 8; k++)
            vecs.push_back(mkv(L, L, '0, '0, H, L, 10'(k), '0, L, H, L, '0,
                               (k > 0), (k > 0) ? 32'(k - 1) : 32'd0, H, L, 10'(k), '0));
        vecs.push_back(mkv(L, L, '0, '0, L, L, '0, '0, L, L, L, '0, H, 32'd7, L, L, '0, '0));
        // Mixed traffic: read followed by write, audio priority against a CPU write
        vecs.push_back(mkv(H, L, 10'd5, '0, L, L, '0, '0, H, L, L, '0, L, '0, H, L, 10'd5, '0));
        vecs.push_back(mkv(L, L, '0, '0, H, H, 10'd20, 32'hA5A5A5A5, L, H, H, 32'h5, L, '0, H, H, 10'd20, 32'hA5A5A5A5));
        vecs.push_back(mkv(H, H, 10'd21, 32'h77, H, L, 10'd20, '0, L, H, L, '0, L, '0, H, L, 10'd20, '0));
        vecs.push_back(mkv(H, H, 10'd21, 32'h77, L, L, '0, '0, H, L, L, '0, H, 32'hA5A5A5A5, H, H, 10'd21, 32'h77));
        vecs.push_back(mkv(H, L, 10'd21, '0, L, L, '0, '0, H, L, L, '0, L, '0, H, L, 10'd21, '0));
        vecs.push_back(mkv(L, L, '0, '0, L, L, '0, '0, L, L, H, 32'h77, L, '0, L, L, '0, '0));
        // Idle stretch
        for (int k = 0; k < 10; k++) vecs.push_back(idle);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
            stepCycle();
        end

        // Starvation: both requesters hold reads for 20 cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 10'd1;
        aud_req = 1'b1; aud_we = 1'b0; aud_adr = 10'd2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
`ifdef STARVE_GUARD_EN
            exp_cpu = ((c % 5) == 4);
`else
            exp_cpu = 1'b0;
`endif
            checkVal($sformatf("starve c%0d cpu_gnt", c), 32'(cpu_gnt), 32'(exp_cpu));
            checkVal($sformatf("starve c%0d aud_gnt", c), 32'(aud_gnt), 32'(!exp_cpu));
            checkVal($sformatf("starve c%0d mem_adr", c), 32'(mem_adr), exp_cpu ? 32'd1 : 32'd2);
            stepCycle();
        end
        applyStimulus(idle);
        stepCycle();

        // Reset lands while an audio read is in flight
        aud_req = 1'b1; aud_we = 1'b0; aud_adr = 10'd7;
        @(negedge clk);
        checkVal("rstmid aud_gnt", 32'(aud_gnt), 32'd1);
        #2;
        reset = 1'b1;
        aud_req = 1'b0;
        #1;
        checkVal("rstmid async mem_en", 32'(mem_en), 32'd0);
        checkVal("rstmid async aud_gnt", 32'(aud_gnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkVal($sformatf("rstmid c%0d mem_en", c),     32'(mem_en),     32'd0);
            checkVal($sformatf("rstmid c%0d aud_rvalid", c), 32'(aud_rvalid), 32'd0);
            checkVal($sformatf("rstmid c%0d aud_rdata", c),  aud_rdata,       32'd0);
        end
        stepCycle();
        reset = 1'b0;
        @(negedge clk);
        checkVal("rstmid post aud_rvalid", 32'(aud_rvalid), 32'd0);
        checkVal("rstmid post cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        stepCycle();
        aud_req = 1'b1; aud_we = 1'b0; aud_adr = 10'd7;
        @(negedge clk);
        checkVal("rstmid reread aud_gnt", 32'(aud_gnt), 32'd1);
        stepCycle();
        aud_req = 1'b0;
        @(negedge clk);
        checkVal("rstmid reread aud_rvalid", 32'(aud_rvalid), 32'd1);
        checkVal("rstmid reread aud_rdata",  aud_rdata,       32'd7);
        checkVal("rstmid reread cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        stepCycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
